// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int FETCH_XLEN  = 32;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous entry FIFO; flush beats push and swallows a same-cycle pop
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output entry_t                     head
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/rom_fetch_unit.sv
// rtl/rom_fetch_unit.sv - ROM instruction fetch with buffered valid/ready output and redirect
// Optional fault detection and HALT state under macro FETCH_FAULT_EN.
module rom_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              ADDR_W     = 5,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [XLEN-1:0]   inst_data,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              fetch_fault,
    output logic              busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef FETCH_FAULT_EN
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } entry_t;
    logic req_fault;
`else
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;
`endif

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            pending;
    logic            issue;
    logic            fault_issue;
    logic            room;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    entry_t          push_data;
    entry_t          head;
    entry_t          shown;
    entry_t          out;

    // Counting the in-flight request guarantees a response never meets a full FIFO.
    assign room = ({1'b0, count} + {{CW{1'b0}}, pending}) < (CW+1)'(FIFO_DEPTH);
    assign push = pending && !redirect_valid;
    assign pop  = inst_valid && inst_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (fault_issue) state_next = HALT;
            HALT:    if (redirect_valid) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        fault_issue = 1'b0;
        if (state == RUN && !redirect_valid && room) begin
            issue = 1'b1;
`ifdef FETCH_FAULT_EN
            fault_issue = (pc[1:0] != 2'b00) || (|pc[XLEN-1:ADDR_W+2]);
`endif
        end
        rom_en   = issue && !fault_issue;
        rom_addr = rom_en ? pc[ADDR_W+1:2] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            req_pc    <= '0;
            pending   <= 1'b0;
            shown     <= '0;
`ifdef FETCH_FAULT_EN
            req_fault <= 1'b0;
`endif
        end else begin
            if (redirect_valid) begin
                pc      <= redirect_pc;
                pending <= 1'b0;
            end else begin
                pending <= issue;
                if (issue) begin
                    pc        <= pc + XLEN'(INSTR_BYTES);
                    req_pc    <= pc;
`ifdef FETCH_FAULT_EN
                    req_fault <= fault_issue;
`endif
                end
            end
            if (pop) begin
                shown <= head;
            end
        end
    end

    always_comb begin
        push_data    = '0;
        push_data.pc = req_pc;
`ifdef FETCH_FAULT_EN
        push_data.fault = req_fault;
        push_data.instr = req_fault ? '0 : rom_data;
`else
        push_data.instr = rom_data;
`endif
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    // While empty the outputs hold the last entry handed over, not stale FIFO slots.
    assign inst_valid = (count != '0);
    assign out        = inst_valid ? head : shown;
    assign inst_data  = out.instr;
    assign inst_pc    = out.pc;
`ifdef FETCH_FAULT_EN
    assign fetch_fault = inst_valid && out.fault;
`else
    assign fetch_fault = 1'b0;
`endif
    assign busy = pending || inst_valid;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb/tb_rom_fetch_unit.sv - scoreboard bench for rom_fetch_unit with a synchronous ROM model
module tb_rom_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rom_en;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_fault;
    logic        busy;

    int errors = 0;
    int checks = 0;
    fetch_entry_t exp_q[$];

    rom_fetch_unit #(
        .XLEN       (32),
        .ADDR_W     (5),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'h1000_0000 + 32'(rom_addr);
    end

    function automatic fetch_entry_t mk(input logic [31:0] p, input logic [31:0] d, input logic f);
        fetch_entry_t e;
        e.pc    = p;
        e.instr = d;
        e.fault = f;
        return e;
    endfunction

    function automatic logic [31:0] rom_word(input int k);
        return 32'h1000_0000 + 32'(k % 32);
    endfunction

    // Every accepted handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            fetch_entry_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got pc=%h data=%h, want no delivery", inst_pc, inst_data);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc, inst_data, fetch_fault} !== {e.pc, e.instr, e.fault}) begin
                    errors++;
                    $display("FAIL sb_entry got pc=%h data=%h fault=%b want pc=%h data=%h fault=%b",
                             inst_pc, inst_data, fetch_fault, e.pc, e.instr, e.fault);
                end
            end
        end
    end

    task automatic start_run(input logic ready);
        exp_q.delete();
        inst_ready     = ready;
        redirect_valid = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({rom_en, rom_addr, inst_valid, inst_data, inst_pc, fetch_fault, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b addr=%h v=%b d=%h pc=%h f=%b busy=%b want all 0",
                     rom_en, rom_addr, inst_valid, inst_data, inst_pc, fetch_fault, busy);
        end
    endtask

    task automatic test_first_fetch();
        int valid_cycles;
        valid_cycles = 0;
        start_run(1'b1);
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(32'(4 * k), rom_word(k), 1'b0));
        checks++;
        if (rom_en !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_idle got en=%b v=%b want 0 0", rom_en, inst_valid);
        end
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (rom_en !== 1'b1 || rom_addr !== 5'd0) begin
                    errors++;
                    $display("FAIL first_request got en=%b addr=%0d want 1 0", rom_en, rom_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_valid got %b in cycle 2 want 0", inst_valid);
                end
            end
            if (c >= 3 && c <= 10 && inst_valid === 1'b1) valid_cycles++;
        end
        inst_ready = 1'b0;
        checks++;
        if (valid_cycles != 8) begin
            errors++;
            $display("FAIL throughput got %0d valid cycles of 8 want 8", valid_cycles);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL first_fetch_drain left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int issues;
        int budget;
        issues = 0;
        budget = 0;
        start_run(1'b0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (rom_en === 1'b1) issues++;
        end
        checks++;
        if (issues != 4) begin
            errors++;
            $display("FAIL full_issue_count got %0d want 4", issues);
        end
        checks++;
        if (rom_en !== 1'b0 || inst_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_state got en=%b v=%b busy=%b want 0 1 1", rom_en, inst_valid, busy);
        end
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(32'(4 * k), rom_word(k), 1'b0));
        inst_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 40) begin
            tick();
            budget++;
        end
        inst_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_drain left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_flush();
        int budget;
        budget = 0;
        start_run(1'b0);
        repeat (5) tick();
        redirect_pc    = 32'h40;
        redirect_valid = 1'b1;
        #1;
        checks++;
        if (rom_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL redirect_cycle got en=%b busy=%b want 0 1", rom_en, busy);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 5'd16 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_request got en=%b addr=%0d v=%b want 1 16 0", rom_en, rom_addr, inst_valid);
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(32'h40 + 32'(4 * k), rom_word(16 + k), 1'b0));
        inst_ready = 1'b1;
        tick();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_early_valid got %b at R+2 want 0", inst_valid);
        end
        while (exp_q.size() != 0 && budget < 40) begin
            tick();
            budget++;
        end
        inst_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_drain left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_handshake();
        int budget;
        budget = 0;
        start_run(1'b1);
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(32'(4 * k), rom_word(k), 1'b0));
        exp_q.push_back(mk(32'h20, rom_word(8), 1'b0));
        exp_q.push_back(mk(32'h24, rom_word(9), 1'b0));
        repeat (5) tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin
            errors++;
            $display("FAIL handshake_head got v=%b pc=%h want 1 00000008", inst_valid, inst_pc);
        end
        redirect_pc    = 32'h20;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 5'd8) begin
            errors++;
            $display("FAIL handshake_redirect_req got en=%b addr=%0d want 1 8", rom_en, rom_addr);
        end
        while (exp_q.size() != 0 && budget < 40) begin
            tick();
            budget++;
        end
        inst_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL handshake_drain left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int budget;
        int issues;
        budget = 0;
        issues = 0;
        start_run(1'b0);
        repeat (2) tick();
        redirect_pc    = 32'h7C;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 5'd31) begin
            errors++;
            $display("FAIL wrap_req_7c got en=%b addr=%0d want 1 31", rom_en, rom_addr);
        end
        exp_q.push_back(mk(32'h7C, rom_word(31), 1'b0));
`ifdef FETCH_FAULT_EN
        exp_q.push_back(mk(32'h80, 32'h0, 1'b1));
`else
        exp_q.push_back(mk(32'h80, rom_word(0), 1'b0));
        exp_q.push_back(mk(32'h84, rom_word(1), 1'b0));
`endif
        inst_ready = 1'b1;
        tick();
        checks++;
`ifdef FETCH_FAULT_EN
        if (rom_en !== 1'b0) begin
            errors++;
            $display("FAIL wrap_fault_req got en=%b want 0", rom_en);
        end
`else
        if (rom_en !== 1'b1 || rom_addr !== 5'd0) begin
            errors++;
            $display("FAIL wrap_req_80 got en=%b addr=%0d want 1 0", rom_en, rom_addr);
        end
`endif
        while (exp_q.size() != 0 && budget < 40) begin
            tick();
            budget++;
        end
        inst_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain left=%0d want 0", exp_q.size());
        end
`ifdef FETCH_FAULT_EN
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rom_en === 1'b1) issues++;
        end
        checks++;
        if (issues != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_quiet got issues=%0d busy=%b want 0 0", issues, busy);
        end
        redirect_pc    = 32'h0;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 5'd0) begin
            errors++;
            $display("FAIL halt_resume got en=%b addr=%0d want 1 0", rom_en, rom_addr);
        end
`endif
    endtask

    task automatic test_reset_mid_stream();
        start_run(1'b0);
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL midstream_setup got busy=%b v=%b want 1 1", busy, inst_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({rom_en, rom_addr, inst_valid, inst_data, inst_pc, fetch_fault, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset got en=%b addr=%h v=%b d=%h pc=%h f=%b busy=%b want all 0",
                     rom_en, rom_addr, inst_valid, inst_data, inst_pc, fetch_fault, busy);
        end
        test_first_fetch();
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_flush();
        test_redirect_handshake();
        test_wrap();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
